// File: rtl/lcd_refresh_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_refresh_ctrl                                                         |
// | Copies a 32-char frame buffer to a 16x2 LCD driver, then sets cursor.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_refresh_ctrl #(
  parameter int CLK_FREQ    = 50000000,
  parameter int INIT_CYCLES = 6500000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       i_clock,
  input  logic       i_internal_reset_n,
  input  logic       i_refresh_req,
  input  logic [4:0] i_cursor_pos,
  input  logic       i_cursor_en,
  output logic [4:0] o_char_addr,
  input  logic [7:0] i_char_data,
  output logic [8:0] o_lcd_d_in,
  output logic       o_lcd_data_ready,
  input  logic       i_lcd_busy_flag,
  output logic       o_refresh_busy,
  output logic       o_refresh_done,
  output logic       o_lcd_error
);

  // CLK_FREQ is documentary: INIT_CYCLES already carries the power-on delay in clocks.
  localparam int c_TIMER_MAX = (INIT_CYCLES > ACK_TIMEOUT) ? INIT_CYCLES : ACK_TIMEOUT;
  localparam int c_TW        = $clog2(c_TIMER_MAX + 1) + ((CLK_FREQ > 0) ? 0 : 1);
  localparam logic [c_TW-1:0] c_INIT_T   = c_TW'(INIT_CYCLES);
  localparam logic [c_TW-1:0] c_ACK_LAST = c_TW'(ACK_TIMEOUT - 1);
  localparam logic [5:0]      c_LAST_IDX = 6'd35;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_PREP = 3'd3,
    S_ACK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_TW-1:0]   r_timer;
  logic [5:0]        r_idx;
  logic [5:0]        w_idx_nxt;
  logic              r_pending;
  logic [4:0]        r_cur_pos;
  logic              r_cur_en;
  logic [4:0]        r_char_addr;
  logic [8:0]        r_d_in;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [8:0]        w_item;
  logic              w_next_is_char;
  logic              w_start;
  logic              w_fire;
  logic              w_timeout;
  logic              w_finish;
  logic              w_next_item;

  always_ff @(posedge i_clock or negedge i_internal_reset_n) begin
    if (!i_internal_reset_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fire      = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    w_next_item = 1'b0;
    case (r_state)
      S_INIT: begin
        if ((r_timer == c_INIT_T) && !i_lcd_busy_flag) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (r_pending || i_refresh_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_PREP;
      end
      S_PREP: begin
        if (!i_lcd_busy_flag) begin
          w_fire      = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (i_lcd_busy_flag) begin
          w_state_nxt = S_DONE;
        end else if (r_timer == c_ACK_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (!i_lcd_busy_flag) begin
          if (r_idx == c_LAST_IDX) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_next_item = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // Item order: 0 = line-1 address, 1..16 chars, 17 = line-2 address, 18..33 chars,
  // 34 = cursor address, 35 = display control.
  assign w_idx_nxt      = r_idx + 6'd1;
  assign w_next_is_char = ((w_idx_nxt >= 6'd1)  && (w_idx_nxt <= 6'd16)) ||
                          ((w_idx_nxt >= 6'd18) && (w_idx_nxt <= 6'd33));

  always_comb begin
    w_item = {1'b1, i_char_data};
    case (r_idx)
      6'd0:    w_item = 9'h080;
      6'd17:   w_item = 9'h0C0;
      6'd34:   w_item = {1'b0, (r_cur_pos[4] ? 4'hC : 4'h8), r_cur_pos[3:0]};
      6'd35:   w_item = {1'b0, 4'h0, 2'b11, r_cur_en, 1'b0};
      default: w_item = {1'b1, i_char_data};
    endcase
  end

  always_ff @(posedge i_clock or negedge i_internal_reset_n) begin
    if (!i_internal_reset_n) begin
      r_timer     <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_cur_pos   <= '0;
      r_cur_en    <= 1'b0;
      r_char_addr <= '0;
      r_d_in      <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_ready <= w_fire;
      r_done  <= w_finish;

      if (r_state == S_INIT) begin
        if (r_timer != c_INIT_T) begin
          r_timer <= r_timer + 1'b1;
        end
      end else if (r_state == S_ACK) begin
        r_timer <= r_timer + 1'b1;
      end else begin
        r_timer <= '0;
      end

      // Requests arriving outside IDLE collapse into a single queued refresh.
      if (w_start || w_timeout) begin
        r_pending <= 1'b0;
      end else if (i_refresh_req && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end

      if (w_start) begin
        r_cur_pos <= i_cursor_pos;
        r_cur_en  <= i_cursor_en;
        r_idx     <= '0;
        r_busy    <= 1'b1;
      end else if (w_finish || w_timeout) begin
        r_busy <= 1'b0;
      end

      // Address is presented for the whole LOAD cycle so RAM data is ready in PREP.
      if (w_next_item) begin
        r_idx <= w_idx_nxt;
        if (w_next_is_char) begin
          r_char_addr <= (w_idx_nxt <= 6'd16) ? 5'(w_idx_nxt - 6'd1) : 5'(w_idx_nxt - 6'd2);
        end
      end

      if (w_fire) begin
        r_d_in <= w_item;
      end

      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_char_addr      = r_char_addr;
  assign o_lcd_d_in       = r_d_in;
  assign o_lcd_data_ready = r_ready;
  assign o_refresh_busy   = r_busy;
  assign o_refresh_done   = r_done;
  assign o_lcd_error      = r_error;

endmodule
`default_nettype wire
